// File: rtl/fsm_sin_mch_if.sv
// Handshake bundle between the sine-run sequencer and its controller / SPI writer.
// Signal names keep the block's _i/_o suffixes as seen from the sequencer.
interface fsm_sin_mch_if #(
    parameter int CNT_W = 10,
    parameter int N_CH  = 2,
    parameter int CH_W  = 1
);
    logic              start_i;
    logic              stop_i;
    logic              cont_i;
    logic [N_CH-1:0]   ch_en_i;
    logic              eow_i;
    logic              strw_o;
    logic [CNT_W-1:0]  addr_o;
    logic [1:0]        quad_o;
    logic              neg_o;
    logic [CH_W-1:0]   ch_o;
    logic              end_o;
    logic              done_o;

    // Driven side: the controller and the SPI writer.
    modport master (
        output start_i, stop_i, cont_i, ch_en_i, eow_i,
        input  strw_o, addr_o, quad_o, neg_o, ch_o, end_o, done_o
    );

    // Sequencer side.
    modport slave (
        input  start_i, stop_i, cont_i, ch_en_i, eow_i,
        output strw_o, addr_o, quad_o, neg_o, ch_o, end_o, done_o
    );
endinterface

// File: rtl/fsm_sin_mch.sv
// Quarter-wave sine sequencer: walks k/quadrant/channel and strobes an SPI writer.
// Continuous (looping) runs exist only when DAC_SIN_CONT_EN is defined.
module fsm_sin_mch #(
    parameter int N_SAMPLES = 20,
    parameter int CNT_W     = 10,
    parameter int N_CH      = 2,
    parameter int CH_W      = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fsm_sin_mch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STRB, WAIT, NEXT} state_t;

    localparam logic [CNT_W-1:0] K_MAX = CNT_W'(N_SAMPLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] k_q;
    logic [1:0]       quad_q;
    logic [CH_W-1:0]  ch_q;
    logic [N_CH-1:0]  en_q;
    logic             cont_q;
    logic             stop_q;
    logic             strw_q;
    logic             end_q;
    logic             done_q;

    logic [N_CH-1:0]  src_en;
    logic [CH_W-1:0]  low_ch;
    logic [CH_W-1:0]  nxt_ch;
    logic             has_nxt;
    logic             finish;
    logic             unused_cont;

    assign unused_cont = bus.cont_i;

    // Lowest enabled channel and next higher enabled channel above ch_q.
    always_comb begin
        src_en  = (state_q == IDLE) ? bus.ch_en_i : en_q;
        low_ch  = '0;
        nxt_ch  = '0;
        has_nxt = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (src_en[i]) begin
                low_ch = CH_W'(i);
            end
            if (en_q[i] && (i > int'(ch_q))) begin
                nxt_ch  = CH_W'(i);
                has_nxt = 1'b1;
            end
        end
    end

    // A run ends on a pending stop or after the final sample of quadrant 3.
    always_comb begin
        finish = stop_q | bus.stop_i |
                 (!has_nxt && (k_q == K_MAX) && (quad_q == 2'd3) && !cont_q);
    end

    // Sequencer state, counters and registered strobe/status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            quad_q  <= '0;
            ch_q    <= '0;
            en_q    <= '0;
            cont_q  <= 1'b0;
            stop_q  <= 1'b0;
            strw_q  <= 1'b0;
            end_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_i && (|bus.ch_en_i)) begin
                        en_q <= bus.ch_en_i;
`ifdef DAC_SIN_CONT_EN
                        cont_q <= bus.cont_i;
`else
                        cont_q <= 1'b0;
`endif
                        k_q     <= '0;
                        quad_q  <= '0;
                        ch_q    <= low_ch;
                        stop_q  <= 1'b0;
                        strw_q  <= 1'b1;
                        end_q   <= 1'b0;
                        state_q <= STRB;
                    end
                end
                STRB: begin
                    strw_q  <= 1'b0;
                    stop_q  <= stop_q | bus.stop_i;
                    state_q <= WAIT;
                end
                WAIT: begin
                    stop_q <= stop_q | bus.stop_i;
                    if (bus.eow_i) begin
                        done_q  <= finish;
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    done_q <= 1'b0;
                    if (done_q) begin
                        stop_q  <= 1'b0;
                        end_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        stop_q  <= stop_q | bus.stop_i;
                        strw_q  <= 1'b1;
                        state_q <= STRB;
                        if (has_nxt) begin
                            ch_q <= nxt_ch;
                        end else begin
                            ch_q <= low_ch;
                            if (k_q == K_MAX) begin
                                k_q    <= '0;
                                quad_q <= quad_q + 2'd1;
                            end else begin
                                k_q <= k_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Odd quadrants read the quarter table backwards.
    assign bus.addr_o = quad_q[0] ? (K_MAX - k_q) : k_q;
    assign bus.quad_o = quad_q;
    assign bus.neg_o  = quad_q[1];
    assign bus.ch_o   = ch_q;
    assign bus.strw_o = strw_q;
    assign bus.end_o  = end_q;
    assign bus.done_o = done_q;
endmodule

// File: tb/tb_fsm_sin_mch.sv
// Directed bench for fsm_sin_mch with N_SAMPLES=4, two channels.
// A per-run table drives the sequencer; the strobe sequence is predicted from the strobe index.
module tb_fsm_sin_mch;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fsm_sin_mch_if #(.CNT_W(4), .N_CH(2), .CH_W(1)) bus ();

    fsm_sin_mch #(
        .N_SAMPLES(4),
        .CNT_W(4),
        .N_CH(2),
        .CH_W(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] en;
        logic       cont;
        int         stop_at;
        int         exp_n;
        bit         hold_eow;
        int         glitch_at;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_strw"}, int'(bus.strw_o), 0);
        chk({tag, "_addr"}, int'(bus.addr_o), 0);
        chk({tag, "_quad"}, int'(bus.quad_o), 0);
        chk({tag, "_neg"}, int'(bus.neg_o), 0);
        chk({tag, "_ch"}, int'(bus.ch_o), 0);
        chk({tag, "_end"}, int'(bus.end_o), 1);
        chk({tag, "_done"}, int'(bus.done_o), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int chs[$];
        int nch, n, dn, eows, cyc, wc, last_eow;
        int s, j, q, k, ea, ech;
        bit pend, ended;
        for (int i = 0; i < 2; i++) begin
            if (v.en[i]) chs.push_back(i);
        end
        nch = chs.size();
        n = 0; dn = 0; eows = 0; wc = 0; last_eow = 0;
        ea = 0; q = 0; ech = 0;
        pend = 1'b0; ended = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.ch_en_i = v.en;
        bus.cont_i  = v.cont;
        @(negedge clk);
        bus.ch_en_i = ~v.en;
        bus.cont_i  = ~v.cont;
        cyc = 1;
        while (!ended && cyc < 1500) begin
            bus.start_i = 1'b0;
            bus.eow_i   = 1'b0;
            bus.stop_i  = 1'b0;
            if (bus.strw_o) begin
                n++;
                s  = n - 1;
                j  = s / nch;
                q  = (j / 4) % 4;
                k  = j % 4;
                ea = (q % 2 == 1) ? 3 - k : k;
                ech = chs[s % nch];
                chk("strb_addr", int'(bus.addr_o), ea);
                chk("strb_quad", int'(bus.quad_o), q);
                chk("strb_neg", int'(bus.neg_o), q / 2);
                chk("strb_ch", int'(bus.ch_o), ech);
                if (n == 1) chk("start_lat", cyc, 1);
                else chk("eow_lat", cyc - last_eow, 2);
                pend = 1'b1;
                wc = 0;
                if (v.hold_eow) bus.eow_i = 1'b1;
                if (n == v.stop_at) bus.stop_i = 1'b1;
                if (n == v.glitch_at) bus.start_i = 1'b1;
            end else if (pend) begin
                wc++;
                chk("wait_addr", int'(bus.addr_o), ea);
                chk("wait_quad", int'(bus.quad_o), q);
                chk("wait_ch", int'(bus.ch_o), ech);
                if (wc == 3) begin
                    bus.eow_i = 1'b1;
                    eows++;
                    pend = 1'b0;
                    last_eow = cyc;
                end
            end
            if (bus.done_o) dn++;
            if (bus.end_o && !pend && (n > 0 || cyc >= 20)) ended = 1'b1;
            @(negedge clk);
            cyc++;
        end
        bus.eow_i   = 1'b0;
        bus.stop_i  = 1'b0;
        bus.start_i = 1'b0;
        chk("run_ended", int'(ended), 1);
        chk("strobes", n, v.exp_n);
        chk("eows", eows, v.exp_n);
        chk("done_pulses", dn, (v.exp_n > 0) ? 1 : 0);
        chk("end_idle", int'(bus.end_o), 1);
    endtask

    vec_t tbl[$];

    initial begin
        int n;
        int cyc;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        bus.cont_i  = 1'b0;
        bus.ch_en_i = 2'b00;
        bus.eow_i   = 1'b0;

        tbl.push_back('{2'b11, 1'b0, 0, 32, 1'b0, 0});
        tbl.push_back('{2'b10, 1'b0, 0, 16, 1'b0, 0});
        tbl.push_back('{2'b01, 1'b0, 0, 16, 1'b0, 0});
        tbl.push_back('{2'b00, 1'b0, 0, 0, 1'b0, 0});
        tbl.push_back('{2'b11, 1'b0, 0, 32, 1'b1, 5});
        tbl.push_back('{2'b11, 1'b0, 12, 12, 1'b0, 0});
`ifdef DAC_SIN_CONT_EN
        tbl.push_back('{2'b11, 1'b1, 40, 40, 1'b0, 0});
`else
        tbl.push_back('{2'b11, 1'b1, 0, 32, 1'b0, 0});
`endif

        #1;
        chk_reset_vals("rst0");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("idle0");

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset during WAIT of strobe 10 (addr 3, quad 1, ch 1).
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.ch_en_i = 2'b11;
        bus.cont_i  = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 10 && cyc < 200) begin
            bus.eow_i = 1'b0;
            if (bus.strw_o) begin
                n++;
                cyc = 0;
            end
            if (n < 10 && cyc == 3) bus.eow_i = 1'b1;
            if (n < 10) begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.eow_i = 1'b0;
        chk("rst_reach10", n, 10);
        chk("pre_rst_addr", int'(bus.addr_o), 3);
        chk("pre_rst_ch", int'(bus.ch_o), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        chk("midrst_done2", int'(bus.done_o), 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", int'(bus.done_o), 0);
            chk("post_rst_strw", int'(bus.strw_o), 0);
        end
        run_vec('{2'b11, 1'b0, 0, 32, 1'b0, 0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fsm_sin_mch.md
FSM_SIN_MCH -- requirements
Module: fsm_sin_mch

Interface
REQ-001 Parameter N_SAMPLES, default 20: points per quarter-wave table; legal range 2..2^CNT_W.
REQ-002 Parameter CNT_W, default 10: width of the sample counter and of addr_o.
REQ-003 Parameter N_CH, default 2: number of DAC channels, legal range 1..2^CH_W.
REQ-004 Parameter CH_W, default 1: width of ch_o.
REQ-005 The block SHALL have these ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  begin a waveform run; level-sampled in IDLE.
- stop_i  in  1  request termination after the current write.
- cont_i  in  1  continuous mode; sampled with start_i.
- ch_en_i  in  N_CH  per-channel enable; sampled with start_i.
- eow_i  in  1  end-of-write pulse from the SPI writer.
- strw_o  out  1  one-cycle write strobe to the SPI writer.
- addr_o  out  CNT_W  quarter-table address for the current write.
- quad_o  out  2  current quadrant, 0..3.
- neg_o  out  1  sign invert for the current sample; high in quadrants 2 and 3.
- ch_o  out  CH_W  channel index for the current write.
- end_o  out  1  high while in IDLE.
- done_o  out  1  one-cycle pulse when a run completes or is stopped.

Function
REQ-006 States SHALL be IDLE, STRB, WAIT and NEXT, with Moore outputs decoded from state and registered counters.
REQ-007 IDLE: end_o=1, strw_o=0; start_i=1 with ch_en_i!=0 SHALL latch ch_en_i and cont_i, clear k, quad and ch to the lowest enabled channel, and go to STRB; start_i with ch_en_i=0 SHALL be ignored.
REQ-008 STRB: strw_o=1 for exactly one cycle, then unconditionally WAIT.
REQ-009 WAIT: hold until eow_i=1, then go to NEXT; eow_i SHALL be ignored in every other state.
REQ-010 NEXT: one cycle; advance to the next higher enabled channel; after the last enabled channel, return to the lowest enabled channel and increment k.
REQ-011 When k reaches N_SAMPLES-1 and the last enabled channel is written, k SHALL wrap to 0 and quad SHALL increment.
REQ-012 After quad 3, sample N_SAMPLES-1, last enabled channel: with latched cont=1, wrap to quad 0, k 0 and go to STRB; otherwise pulse done_o in NEXT and go to IDLE.
REQ-013 addr_o SHALL be k in quadrants 0 and 2 and N_SAMPLES-1-k in quadrants 1 and 3; neg_o=quad[1].
REQ-014 addr_o, quad_o, neg_o and ch_o SHALL be stable from STRB through the end of WAIT.
REQ-015 stop_i=1 at any cycle outside IDLE SHALL set a sticky flag; the next NEXT SHALL pulse done_o and go to IDLE, so the in-flight write always completes.
REQ-016 start_i outside IDLE SHALL be ignored; changes to ch_en_i or cont_i outside IDLE SHALL have no effect.
REQ-017 Write latency: start_i sampled high -> strw_o high on the next cycle; eow_i high -> next strw_o 2 cycles later.

Reset
REQ-018 rst_i=1 SHALL immediately force IDLE, with k, quad, ch, the stop flag and latched enables all zero.
REQ-019 Reset values: strw_o=0, addr_o=0, quad_o=0, neg_o=0, ch_o=0, end_o=1, done_o=0; a reset mid-run SHALL NOT pulse done_o.

Configuration
REQ-020 With macro DAC_SIN_CONT_EN defined, cont_i SHALL behave as in REQ-012.
REQ-021 With DAC_SIN_CONT_EN undefined, cont_i SHALL be ignored, latched cont is constant 0, and every run is single-shot.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- N_SAMPLES=4, N_CH=2, ch_en_i=2'b11, cont_i=0, eow_i 3 cycles after each strobe: 32 strobes; addr_o sequence per quadrant 0,1,2,3 / 3,2,1,0 / 0,1,2,3 / 3,2,1,0; neg_o=1 on strobes 17-32; ch_o alternates 0,1; done_o pulses once; end_o returns to 1.
- ch_en_i=2'b10: 16 strobes, all with ch_o=1; ch_en_i=2'b00 with start_i=1: no strobe, end_o stays 1.
- cont_i=1 with DAC_SIN_CONT_EN defined: strobe 33 has quad_o=0, addr_o=0; stop_i pulsed at strobe 40 -> exactly one more eow, done_o pulse, then IDLE.
- Same stimulus with DAC_SIN_CONT_EN undefined: stops after 32 strobes.
- rst_i asserted in WAIT at strobe 10: outputs take reset values in the same cycle, no done_o pulse; a new start_i restarts at addr_o=0, quad_o=0.
- eow_i held high during STRB, and start_i pulsed mid-run: no extra strobes and no sequence skip.
